// File: rtl/debounce_pulse.sv
// debounce_pulse
//   Turns a raw, bouncing pushbutton into a clean one-cycle Inc pulse. The
//   pulse feeds a mod-4 counter. A debounced Level output is also provided.
//   Btn passes through a two-flop synchroniser. A four-state FSM with a
//   stability counter then debounces the synchronised signal.
//
// Parameters
//   DB_CYCLES : number of consecutive stable synchronised samples needed to
//               accept an edge (must be >= 2)
//   CNT_W     : stability counter width; 2**CNT_W must exceed DB_CYCLES-1
//
// Ports
//   Clk   : system clock, rising edge
//   Reset : synchronous active-high reset
//   Btn   : raw asynchronous pushbutton, 1 = pressed
//   Inc   : one-cycle pulse per debounced press (registered)
//   Level : debounced button level, 1 = pressed (registered)
module debounce_pulse #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 19
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Btn,
  output logic Inc,
  output logic Level
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    DB_PRESS   = 2'b01,
    HELD       = 2'b10,
    DB_RELEASE = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             s1_reg, s2_reg;
  logic             inc_reg, inc_next;
  logic             level_reg, level_next;
  logic             btn_s;

  assign btn_s = s2_reg;
  assign Inc   = inc_reg;
  assign Level = level_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_reg    <= 1'b0;
      s2_reg    <= 1'b0;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      inc_reg   <= 1'b0;
      level_reg <= 1'b0;
    end else begin
      s1_reg    <= Btn;
      s2_reg    <= s1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      inc_reg   <= inc_next;
      level_reg <= level_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    inc_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (btn_s) begin
          state_next = DB_PRESS;
          cnt_next   = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          // The only path into HELD that emits a pulse. Re-entry from
          // DB_RELEASE is a bounce on release, not a new press.
          state_next = HELD;
          cnt_next   = '0;
          inc_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_next = DB_RELEASE;
          cnt_next   = '0;
        end
      end
      DB_RELEASE: begin
        if (btn_s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // Level is decoded from the next state so that it rises together with Inc.
    level_next = (state_next == HELD) || (state_next == DB_RELEASE);
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// tb_debounce_pulse
//   Directed bench for debounce_pulse with DB_CYCLES=4 and CNT_W=3.
//   Expected Inc/Level values are checked cycle by cycle.
//   A small mod-4 counter stands in for the downstream consumer of Inc.
module tb_debounce_pulse;

  logic Clk;
  logic Reset;
  logic Btn;
  logic Inc;
  logic Level;

  int errors;
  int checks;
  int inc_total;
  int inc_mark;
  logic [1:0] q;

  debounce_pulse #(
    .DB_CYCLES(4),
    .CNT_W    (3)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Btn  (Btn),
    .Inc  (Inc),
    .Level(Level)
  );

  always #5 Clk = ~Clk;

  // Downstream mod-4 counter stand-in.
  always @(posedge Clk) begin
    if (Reset) q <= 2'd0;
    else if (Inc) q <= q + 2'd1;
  end

  // Running total of Inc pulses, sampled away from the active edge.
  always @(negedge Clk) begin
    if (Inc === 1'b1) inc_total = inc_total + 1;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input logic exp_inc, input logic exp_level, input string tag);
    checks = checks + 1;
    assert (Inc === exp_inc) else begin
      errors = errors + 1;
      $error("FAIL %s Inc observed=%b expected=%b", tag, Inc, exp_inc);
    end
    checks = checks + 1;
    assert (Level === exp_level) else begin
      errors = errors + 1;
      $error("FAIL %s Level observed=%b expected=%b", tag, Level, exp_level);
    end
  endtask

  task automatic run(input int n, input logic exp_inc, input logic exp_level, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(exp_inc, exp_level, tag);
    end
  endtask

  task automatic chk_int(input int observed, input int expected, input string tag);
    checks = checks + 1;
    assert (observed === expected) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    inc_total = 0;
    Clk       = 1'b0;
    Reset     = 1'b1;
    Btn       = 1'b0;

    // 1: reset state, then idle with the button released
    tick();
    tick();
    chk(1'b0, 1'b0, "reset");
    chk_int(int'(dut.state_reg), 0, "reset_state");
    Reset = 1'b0;
    run(20, 1'b0, 1'b0, "idle");
    chk_int(inc_total, 0, "idle_inc_count");

    // 2: clean press, long hold, clean release
    inc_mark = inc_total;
    Btn = 1'b1;
    run(6, 1'b0, 1'b0, "t2_pre");
    run(1, 1'b1, 1'b1, "t2_inc");
    run(13, 1'b0, 1'b1, "t2_hold");
    Btn = 1'b0;
    run(6, 1'b0, 1'b1, "t2_rel");
    run(1, 1'b0, 1'b0, "t2_low");
    chk_int(inc_total - inc_mark, 1, "t2_inc_count");
    run(3, 1'b0, 1'b0, "t2_idle");

    // 3: press too short to be accepted
    inc_mark = inc_total;
    Btn = 1'b1;
    run(3, 1'b0, 1'b0, "t3_short");
    Btn = 1'b0;
    run(12, 1'b0, 1'b0, "t3_after");
    chk_int(int'(dut.state_reg), 0, "t3_state_idle");
    chk_int(inc_total - inc_mark, 0, "t3_inc_count");

    // 4: bounce 1,0,1,0,1,0, then steady press from edge m
    inc_mark = inc_total;
    for (int i = 0; i < 6; i++) begin
      Btn = (i % 2 == 0);
      run(1, 1'b0, 1'b0, "t4_bounce");
    end
    Btn = 1'b1;
    run(6, 1'b0, 1'b0, "t4_pre");
    run(1, 1'b1, 1'b1, "t4_inc");
    run(3, 1'b0, 1'b1, "t4_hold");
    Btn = 1'b0;
    run(6, 1'b0, 1'b1, "t4_rel");
    run(1, 1'b0, 1'b0, "t4_low");
    chk_int(inc_total - inc_mark, 1, "t4_inc_count");

    // 5: reset pulse mid-count while the button stays held
    inc_mark = inc_total;
    Btn = 1'b1;
    run(5, 1'b0, 1'b0, "t5_count");
    chk_int(int'(dut.cnt_reg), 2, "t5_cnt_at_reset");
    Reset = 1'b1;
    run(1, 1'b0, 1'b0, "t5_reset");
    Reset = 1'b0;
    run(6, 1'b0, 1'b0, "t5_recount");
    run(1, 1'b1, 1'b1, "t5_inc");
    run(2, 1'b0, 1'b1, "t5_hold");
    Btn = 1'b0;
    run(6, 1'b0, 1'b1, "t5_rel");
    run(1, 1'b0, 1'b0, "t5_low");
    chk_int(inc_total - inc_mark, 1, "t5_inc_count");

    // 6: three press/release cycles step the mod-4 counter 0->1->2->3
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_int(int'(q), 0, "t6_q_start");
    for (int p = 1; p <= 3; p++) begin
      Btn = 1'b1;
      run(6, 1'b0, 1'b0, "t6_pre");
      run(1, 1'b1, 1'b1, "t6_inc");
      run(4, 1'b0, 1'b1, "t6_hold");
      chk_int(int'(q), p, "t6_q");
      Btn = 1'b0;
      run(6, 1'b0, 1'b1, "t6_rel");
      run(1, 1'b0, 1'b0, "t6_low");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
